tiny_calc_ctrl: RTL and testbench

TINY_CALC_CTRL -- requirements
Module: tiny_calc_ctrl

---
 rtl/tiny_calc_pkg.sv | 44 ++++
 rtl/tiny_calc_ctrl_adder4.sv | 13 +
 rtl/tiny_calc_ctrl.sv | 142 ++++++++++++++
 tb/tb_tiny_calc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_calc_pkg.sv
// Shared types and helpers for the tiny calculator controller.
package tiny_calc_pkg;

  localparam int unsigned CALC_W = 4;
  localparam int unsigned RES_W  = 2 * CALC_W;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } calc_state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } calc_op_e;

  // Active-low 7-segment decode, bit order gfedcba.
  function automatic logic [SEG_W-1:0] hex_to_seg7(input logic [CALC_W-1:0] d);
    logic [SEG_W-1:0] seg;
    case (d)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tiny_calc_ctrl_adder4.sv
// Single shared 4-bit ripple adder used by both add and shift-add multiply.
module adder4
  import tiny_calc_pkg::*;
(
  input  logic [CALC_W-1:0] i_a,
  input  logic [CALC_W-1:0] i_b,
  output logic [CALC_W-1:0] o_sum,
  output logic              o_cout
);

  assign {o_cout, o_sum} = (CALC_W+1)'(i_a) + (CALC_W+1)'(i_b);

endmodule

// File: rtl/tiny_calc_ctrl.sv
// Key-triggered 4-bit add / shift-add multiply controller with 7-segment outputs.
module tiny_calc_ctrl
  import tiny_calc_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [RES_W-1:0]   i_sw,
  input  logic               i_start,
  input  logic               i_op,
  output logic               o_busy,
  output logic               o_done,
  output logic [SEG_W-1:0]   o_hex0,
  output logic [SEG_W-1:0]   o_hex1,
  output logic [SEG_W-1:0]   o_hex2,
  output logic [SEG_W-1:0]   o_hex3
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_FIN  = FIN;
  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_start_q;
  logic              r_armed;
  logic [CALC_W-1:0] r_a;
  logic [CALC_W-1:0] r_b;
  calc_op_e          r_op;
  logic [CALC_W-1:0] r_hi;
  logic [CALC_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [RES_W-1:0]  r_result;
  logic              r_busy;
  logic              r_done;
  logic [SEG_W-1:0]  r_hex0;
  logic [SEG_W-1:0]  r_hex1;
  logic [SEG_W-1:0]  r_hex2;
  logic [SEG_W-1:0]  r_hex3;

  logic              w_start_edge;
  logic              w_is_mul;
  logic              w_last;
  logic [CALC_W-1:0] w_add_a;
  logic [CALC_W-1:0] w_add_b;
  logic [CALC_W-1:0] w_sum;
  logic              w_cout;
  logic [CALC_W-1:0] w_mul_hi;
  logic [CALC_W-1:0] w_mul_lo;
  logic [RES_W-1:0]  w_result;

  // r_armed blocks a START that was already held through reset.
  assign w_start_edge = i_start & ~r_start_q & r_armed;
  assign w_is_mul     = (r_op == OP_MUL);
  assign w_last       = !w_is_mul || (r_cnt == CNT_W'(3));

  // Multiply feeds hi and (A or 0) into the adder; add feeds A and B.
  assign w_add_a = w_is_mul ? r_hi : r_a;
  assign w_add_b = w_is_mul ? (r_lo[0] ? r_a : '0) : r_b;

  adder4 u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_mul_hi = {w_cout, w_sum[CALC_W-1:1]};
  assign w_mul_lo = {w_sum[0], r_lo[CALC_W-1:1]};
  assign w_result = w_is_mul ? {w_mul_hi, w_mul_lo}
                             : {(CALC_W-1)'(0), w_cout, w_sum};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hex0    <= SEG_ZERO;
      r_hex1    <= SEG_ZERO;
      r_hex2    <= SEG_ZERO;
      r_hex3    <= SEG_ZERO;
    end else begin
      r_start_q <= i_start;
      if (!i_start) r_armed <= 1'b1;
      r_busy <= (w_state_nxt == S_EXEC);
      r_done <= (w_state_nxt == S_FIN);
      if ((r_state == S_IDLE) && w_start_edge) begin
        r_a    <= i_sw[CALC_W-1:0];
        r_b    <= i_sw[RES_W-1:CALC_W];
        r_op   <= calc_op_e'(i_op);
        r_hi   <= '0;
        r_lo   <= i_sw[RES_W-1:CALC_W];
        r_cnt  <= '0;
        r_hex0 <= hex_to_seg7(i_sw[CALC_W-1:0]);
        r_hex1 <= hex_to_seg7(i_sw[RES_W-1:CALC_W]);
      end
      if (r_state == S_EXEC) begin
        if (w_is_mul) begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_last) begin
          r_result <= w_result;
          r_hex2   <= hex_to_seg7(w_result[CALC_W-1:0]);
          r_hex3   <= hex_to_seg7(w_result[RES_W-1:CALC_W]);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hex0 = r_hex0;
  assign o_hex1 = r_hex1;
  assign o_hex2 = r_hex2;
  assign o_hex3 = r_hex3;

endmodule

// File: tb/tb_tiny_calc_ctrl.sv
// Self-checking bench for tiny_calc_ctrl against an arithmetic reference model.
module tb_tiny_calc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       start;
  logic       op;
  logic       busy;
  logic       done;
  logic [6:0] hex0, hex1, hex2, hex3;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  tiny_calc_ctrl dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sw    (sw),
    .i_start (start),
    .i_op    (op),
    .o_busy  (busy),
    .o_done  (done),
    .o_hex0  (hex0),
    .o_hex1  (hex1),
    .o_hex2  (hex2),
    .o_hex3  (hex3)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sw = 8'h00; op = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({hex3, hex2, hex1, hex0} !== {4{seg_tbl[0]}}) begin
      n_err++; $display("FAIL reset_hex got %h expected %h", {hex3, hex2, hex1, hex0}, {4{seg_tbl[0]}});
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b expected 0", done); end
  endtask

  // Runs one operation and checks cycle-by-cycle BUSY/DONE plus final displays.
  task automatic test_operation(input logic [3:0] a, input logic [3:0] b, input logic m);
    int         lat;
    logic [7:0] res;
    lat = m ? 5 : 2;
    res = m ? (8'(a) * 8'(b)) : (8'(a) + 8'(b));
    @(negedge clk);
    sw = {b, a}; op = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      n_vec++;
      if ({busy, done} !== {(cyc < lat), (cyc == lat)}) begin
        n_err++;
        $display("FAIL timing a=%h b=%h op=%b cyc=%0d got busy/done=%b%b expected %b%b",
                 a, b, m, cyc, busy, done, (cyc < lat), (cyc == lat));
      end
      @(negedge clk);
    end
    n_vec++; if ({hex1, hex0} !== {seg_tbl[b], seg_tbl[a]}) begin
      n_err++; $display("FAIL operand_hex a=%h b=%h got %h expected %h", a, b, {hex1, hex0}, {seg_tbl[b], seg_tbl[a]});
    end
    n_vec++; if ({hex3, hex2} !== {seg_tbl[res[7:4]], seg_tbl[res[3:0]]}) begin
      n_err++; $display("FAIL result_hex a=%h b=%h op=%b got %h expected %h (result %h)",
                        a, b, m, {hex3, hex2}, {seg_tbl[res[7:4]], seg_tbl[res[3:0]]}, res);
    end
  endtask

  task automatic test_directed();
    test_operation(4'h3, 4'h2, 1'b0);
    test_operation(4'hF, 4'hF, 1'b0);
    test_operation(4'hF, 4'hF, 1'b1);
  endtask

  task automatic test_hold_displays();
    sw = 8'h00; op = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({hex3, hex2, hex1, hex0} !== {seg_tbl[14], seg_tbl[1], seg_tbl[15], seg_tbl[15]}) begin
      n_err++; $display("FAIL hold_displays got %h expected %h", {hex3, hex2, hex1, hex0},
                        {seg_tbl[14], seg_tbl[1], seg_tbl[15], seg_tbl[15]});
    end
  endtask

  task automatic test_ignore_restart();
    int pulses;
    pulses = 0;
    @(negedge clk);
    sw = 8'h07; op = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = (cyc == 2);
      if (cyc == 2) sw = 8'h55;
      if (done === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL restart_pulses got %0d expected 1", pulses); end
    n_vec++; if ({hex3, hex2, hex1, hex0} !== {seg_tbl[0], seg_tbl[0], seg_tbl[0], seg_tbl[7]}) begin
      n_err++; $display("FAIL restart_hex got %h expected %h", {hex3, hex2, hex1, hex0},
                        {seg_tbl[0], seg_tbl[0], seg_tbl[0], seg_tbl[7]});
    end
  endtask

  task automatic test_held_start();
    int pulses;
    pulses = 0;
    @(negedge clk);
    sw = 8'h46; op = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 10) start = 1'b0;
      if (done === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL held_pulses got %0d expected 1", pulses); end
    n_vec++; if ({hex3, hex2} !== {seg_tbl[0], seg_tbl[10]}) begin
      n_err++; $display("FAIL held_result got %h expected %h", {hex3, hex2}, {seg_tbl[0], seg_tbl[10]});
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    @(negedge clk);
    sw = 8'h99; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if ({hex3, hex2, hex1, hex0} !== {4{seg_tbl[0]}}) begin
      n_err++; $display("FAIL midrst_hex got %h expected %h", {hex3, hex2, hex1, hex0}, {4{seg_tbl[0]}});
    end
    n_vec++; if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL midrst_flags got %b%b expected 00", busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL midrst_activity got %0d expected 0", pulses); end
    test_operation(4'h9, 4'h9, 1'b1);
  endtask

  task automatic test_reset_start_held();
    int active;
    active = 0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; sw = 8'h21; op = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) active++;
    end
    n_vec++; if (active != 0) begin n_err++; $display("FAIL held_through_reset got %0d expected 0", active); end
    start = 1'b0;
    test_operation(4'h1, 4'h2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      test_operation(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_displays();
    test_ignore_restart();
    test_held_start();
    test_reset_mid_op();
    test_reset_start_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
